exc_ctrl: RTL
=============

# exc_ctrl

Exception/interrupt sequencer for the P7 pipeline. Sits beside CP0 at the M-stage commit point. Each cycle it picks one event: hardware interrupt, synchronous exception carried down with the M-stage instruction, or ERET. It then drives CP0 update strobes, flushes the pipeline and redirects fetch through a small state machine. CP0 only stores state; this block decides when and what CP0 records.

## Interface
- HANDLER_ADDR, 32'h0000_4180, fetch address of the exception handler
- DRAIN_CYCLES, 2, cycles (1..7) after a redirect during which new events are masked
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_valid  in  1  M stage holds a real instruction (0 = bubble)
- m_pc  in  32  PC of the M-stage instruction
- m_exc  in  1  M-stage instruction carries a synchronous exception
- m_exc_code  in  5  ExcCode of that exception
- m_bd  in  1  M-stage instruction sits in a branch/jump delay slot
- m_eret  in  1  M-stage instruction is ERET
- hw_int  in  6  HWInt[7:2] level inputs
- sr_im  in  6  SR.IM[7:2] from CP0
- sr_ie  in  1  SR.IE from CP0
- sr_exl  in  1  SR.EXL from CP0
- cp0_epc  in  32  current EPC from CP0
- cp0_exc_we  out  1  one-cycle strobe: CP0 latches EPC/Cause and sets EXL
- cp0_exc_code  out  5  ExcCode to record (0 for interrupt)
- cp0_epc_out  out  32  EPC to record, word-aligned
- cp0_bd_out  out  1  Cause.BD to record
- cp0_exl_clr  out  1  one-cycle strobe: CP0 clears EXL (ERET)
- flush  out  1  kill all instructions in F/D/E/M; M result and store suppressed
- redirect  out  1  fetch PC is replaced by redirect_pc on the next edge
- redirect_pc  out  32  redirect target
- busy  out  1  state != IDLE

## Operation
- Interrupt request: int_req = sr_ie & ~sr_exl & |(hw_int & sr_im).
- Event selection happens only in IDLE, and only with m_valid=1. Priority: int_req > (m_exc & ~sr_exl) > (m_eret & sr_exl). Lower-priority events in the same cycle are discarded; the flush kills their instructions.
- Exception/interrupt taken at cycle T:
  - cp0_exc_we=1 and flush=1.
  - cp0_exc_code = 0 for an interrupt, else m_exc_code.
  - EPC/BD from m_pc, m_bd (see Configuration).
- ERET taken at cycle T: cp0_exl_clr=1, flush=1, latch cp0_epc into the internal target register.
- States:
  - IDLE: on a taken event, latch the target (HANDLER_ADDR or cp0_epc) and go to REDIR.
  - REDIR: redirect=1, flush=1, redirect_pc = latched target. Load drain counter with DRAIN_CYCLES and go to DRAIN.
  - DRAIN: decrement every cycle; at 1 go to IDLE. All inputs are ignored and no strobes are issued.
- Interrupt with m_valid=0 (bubble): not taken, stays pending while hw_int is held. It is taken at the first cycle with a valid M instruction.
- m_exc with sr_exl=1: ignored and no strobe; the instruction commits normally.
- m_eret with sr_exl=0: treated as NOP.
- hw_int is level-sensitive and not latched. A pulse dropped before selection is lost.

## Timing
- Reset (any state, any cycle): state=IDLE, counter=0, target=0. All outputs are 0 in the cycle after the reset edge and remain so while reset=1.
- Strobes and the first flush are combinational in cycle T. CP0 updates at the T/T+1 edge.
- redirect is registered: asserted only in T+1. The handler's first fetch happens at T+2.
- busy=1 from T+1 through T+1+DRAIN_CYCLES inclusive. The next event can be taken at T+2+DRAIN_CYCLES at the earliest.
- cp0_exc_we and cp0_exl_clr are never high together and never high for two consecutive cycles.

## Configuration
- Macro EXC_DELAY_SLOT_EN.
- Defined: when m_bd=1, cp0_epc_out={m_pc[31:2],2'b00}-4 and cp0_bd_out=1. When m_bd=0, cp0_epc_out={m_pc[31:2],2'b00} and cp0_bd_out=0.
- Undefined: m_bd is ignored; cp0_epc_out={m_pc[31:2],2'b00} and cp0_bd_out=0 always.

## Test plan
- Reset for 3 cycles then release, all inputs 0: every output stays 0 and busy=0 for 10 cycles.
- m_valid=1, m_exc=1, m_exc_code=10, m_pc=0x3010, sr_exl=0: at T cp0_exc_we=1, cp0_exc_code=10, cp0_epc_out=0x3010, flush=1. At T+1 redirect=1, redirect_pc=0x4180. busy=0 at T+4.
- sr_ie=1, sr_im=6'b000001, hw_int=6'b000001 and m_exc=1 with code 4 in the same cycle: cp0_exc_code=0, exactly one cp0_exc_we pulse.
- m_eret=1, sr_exl=1, cp0_epc=0x3024: at T cp0_exl_clr=1. At T+1 redirect=1, redirect_pc=0x3024. With sr_exl=0, no strobe, no flush.
- EXC_DELAY_SLOT_EN defined, m_bd=1, m_pc=0x3008, interrupt pending: cp0_epc_out=0x3004, cp0_bd_out=1. Undefined: 0x3008 and 0.
- Interrupt held while m_valid=0 for 3 cycles, then m_valid=1: the strobe fires in the first valid cycle. A second interrupt during DRAIN is not taken until IDLE. Reset asserted during REDIR leaves redirect=0 on the next cycle.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: M-stage exception/interrupt/ERET sequencer beside CP0.
// Optional macro EXC_DELAY_SLOT_EN: record delay-slot EPC/BD from m_bd.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_exc,
  input  logic [4:0]  m_exc_code,
  input  logic        m_bd,
  input  logic        m_eret,
  input  logic [5:0]  hw_int,
  input  logic [5:0]  sr_im,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [31:0] cp0_epc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exc_code,
  output logic [31:0] cp0_epc_out,
  output logic        cp0_bd_out,
  output logic        cp0_exl_clr,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] rpc_q, rpc_d;
  logic        busy_q, busy_d;

  logic        int_req;
  logic        sel_ok;
  logic        take_int;
  logic        take_exc;
  logic        take_eret;
  logic        take_trap;
  logic [31:0] epc_base;
  logic [31:0] epc_rec;
  logic        bd_rec;
  logic        unused_pc_lsb;

  assign int_req   = sr_ie & ~sr_exl & |(hw_int & sr_im);
  assign sel_ok    = (state_q == IDLE) & m_valid & ~reset;
  assign take_int  = sel_ok & int_req;
  assign take_exc  = sel_ok & ~int_req & m_exc & ~sr_exl;
  assign take_eret = sel_ok & ~int_req & ~(m_exc & ~sr_exl)
                   & m_eret & sr_exl;
  assign take_trap = take_int | take_exc;

  assign epc_base      = {m_pc[31:2], 2'b00};
  assign unused_pc_lsb = ^m_pc[1:0];

`ifdef EXC_DELAY_SLOT_EN
  // A trapped delay-slot instruction must restart at its branch.
  assign epc_rec = m_bd ? epc_base - 32'd4 : epc_base;
  assign bd_rec  = m_bd;
`else
  logic unused_bd;
  assign unused_bd = m_bd;
  assign epc_rec   = epc_base;
  assign bd_rec    = 1'b0;
`endif

  always_comb begin
    cp0_exc_we   = take_trap;
    cp0_exc_code = take_exc ? m_exc_code : 5'd0;
    cp0_epc_out  = take_trap ? epc_rec : 32'd0;
    cp0_bd_out   = take_trap & bd_rec;
    cp0_exl_clr  = take_eret;
    flush        = take_trap | take_eret | (redirect_q & ~reset);
    redirect     = redirect_q;
    redirect_pc  = rpc_q;
    busy         = busy_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          tgt_d   = HANDLER_ADDR;
          state_d = REDIR;
        end else if (take_eret) begin
          tgt_d   = cp0_epc;
          state_d = REDIR;
        end
      end
      REDIR: begin
        cnt_d   = DRAIN_CYCLES[2:0];
        state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    redirect_d = (state_d == REDIR);
    rpc_d      = redirect_d ? tgt_d : 32'd0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      tgt_q      <= 32'd0;
      redirect_q <= 1'b0;
      rpc_q      <= 32'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      busy_q     <= busy_d;
    end
  end

endmodule
